// File: rtl/pulse_train_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_pkg
// Description : Shared types and constants for the pulse train driver.
//               - state_t          : controller state encoding
//               - DEFAULT_*_CYCLES : default ON/OFF durations (20 ms @ 100 MHz)
//               - timer_width()    : width needed for the ON/OFF period timer
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_train_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    localparam int DEFAULT_ON_CYCLES  = 2000000;
    localparam int DEFAULT_OFF_CYCLES = 2000000;

    // Bits needed to hold the larger of the two period lengths without wrap.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : pulse_timer
// Description : Loadable down-counter. After a load of value V the expired
//               flag rises V cycles later, so loading (period - 1) yields a
//               phase of exactly 'period' cycles.
// Ports       : clk        - system clock, rising edge
//               reset      - asynchronous, active-low reset
//               load       - load load_value into the counter
//               load_value - value to load
//               expired    - counter has reached zero
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            // Saturates at zero so the counter can never wrap.
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pulse_train_driver.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_driver
// Description : Emits a train of cmd_count pulses on drive_out. Each pulse is
//               ON_CYCLES high followed by OFF_CYCLES low (the low gap also
//               follows the last pulse). done strobes for one cycle on return
//               to IDLE. All outputs are registered.
// Config      : PULSE_ABORT_EN - adds the abort input to end a train early.
// Ports       : clk       - system clock, rising edge
//               reset     - asynchronous, active-low reset
//               cmd_valid - command request
//               cmd_ready - idle, able to accept a command
//               cmd_count - number of pulses, sampled on acceptance
//               drive_out - actuator drive
//               busy      - train in progress
//               done      - one-cycle completion strobe
//               abort     - stop train early (PULSE_ABORT_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_train_driver
    import pulse_train_pkg::*;
#(
    parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int OFF_CYCLES = DEFAULT_OFF_CYCLES,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             drive_out,
    output logic             busy,
    output logic             done
`ifdef PULSE_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int                 TIMER_W   = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam logic [TIMER_W-1:0] ON_LOAD   = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD  = TIMER_W'(OFF_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   w_remaining_next;
    logic [CNT_W-1:0]   w_remaining_eff;
    logic               w_done_next;
    logic               w_load;
    logic [TIMER_W-1:0] w_load_value;
    logic               w_expired;
    logic               w_abort;

`ifdef PULSE_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    pulse_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (w_load),
        .load_value (w_load_value),
        .expired    (w_expired)
    );

    // An abort during OFF discards the pulses still owed; the OFF gap runs on.
    assign w_remaining_eff = w_abort ? '0 : r_remaining;

    always_comb begin
        w_state_next     = r_state;
        w_remaining_next = r_remaining;
        w_done_next      = 1'b0;
        w_load           = 1'b0;
        w_load_value     = '0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_count != '0) begin
                        w_state_next     = ST_ON;
                        w_remaining_next = cmd_count;
                        w_load           = 1'b1;
                        w_load_value     = ON_LOAD;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end

            ST_ON: begin
                if (w_abort) begin
                    w_state_next     = ST_OFF;
                    w_remaining_next = '0;
                    w_load           = 1'b1;
                    w_load_value     = OFF_LOAD;
                end else if (w_expired) begin
                    w_state_next = ST_OFF;
                    w_load       = 1'b1;
                    w_load_value = OFF_LOAD;
                end
            end

            ST_OFF: begin
                if (w_expired) begin
                    // r_remaining counts the pulse just finished, so >1 means more to go.
                    if (w_remaining_eff > CNT_W'(1)) begin
                        w_state_next     = ST_ON;
                        w_remaining_next = w_remaining_eff - CNT_W'(1);
                        w_load           = 1'b1;
                        w_load_value     = ON_LOAD;
                    end else begin
                        w_state_next     = ST_IDLE;
                        w_remaining_next = '0;
                        w_done_next      = 1'b1;
                    end
                end else begin
                    w_remaining_next = w_remaining_eff;
                end
            end

            default: begin
                w_state_next     = ST_IDLE;
                w_remaining_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge
    // as the state register and are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            drive_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_remaining <= w_remaining_next;
            drive_out   <= (w_state_next == ST_ON);
            busy        <= (w_state_next != ST_IDLE);
            done        <= w_done_next;
            cmd_ready   <= (w_state_next == ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: doc/pulse_train_driver.md
PULSE_TRAIN_DRIVER -- requirements
Module: pulse_train_driver

Interface
REQ-001 Parameter ON_CYCLES, default 2000000; drive_out high time per pulse in clk cycles (20 ms at 100 MHz); SHALL be >= 1.
REQ-002 Parameter OFF_CYCLES, default 2000000; drive_out low time after every pulse in clk cycles; SHALL be >= 1.
REQ-003 Parameter CNT_W, default 4; width of cmd_count.
REQ-004 clk  input  1  system clock, 100 MHz, rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  block idle; can accept a command.
REQ-008 cmd_count  input  CNT_W  number of pulses to emit; sampled on acceptance.
REQ-009 drive_out  output  1  actuator/buzzer drive, glitch-free.
REQ-010 busy  output  1  high in any non-IDLE state.
REQ-011 done  output  1  one-cycle completion strobe.
REQ-012 abort  input  1  stop the train early; present only with PULSE_ABORT_EN.

Function
REQ-013 States: IDLE, ON, OFF; all outputs SHALL be registered.
REQ-014 Acceptance occurs on a rising edge where cmd_valid && cmd_ready; cmd_ready SHALL be high only in IDLE.
REQ-015 On acceptance with cmd_count = n > 0: IDLE -> ON; drive_out SHALL go high in the cycle after acceptance.
REQ-016 ON SHALL last exactly ON_CYCLES cycles with drive_out high, then OFF for exactly OFF_CYCLES cycles with drive_out low.
REQ-017 After each OFF period: remaining count decrements; if nonzero -> ON, else -> IDLE.
REQ-018 The OFF period SHALL also follow the final pulse, guaranteeing the minimum low gap before any next command.
REQ-019 done SHALL pulse high for exactly one cycle, coinciding with the first cycle of IDLE (cmd_ready high), i.e. acceptance cycle + 1 + n*(ON_CYCLES+OFF_CYCLES).
REQ-020 cmd_count = 0: accepted, no pulse, drive_out stays low, done one cycle after acceptance.
REQ-021 cmd_valid while busy SHALL be ignored (no queueing); cmd_count changes while busy SHALL have no effect.
REQ-022 Cycle counter SHALL be wide enough for max(ON_CYCLES, OFF_CYCLES) with no wrap-around; remaining-count register CNT_W bits, never underflows.
REQ-023 drive_out SHALL never toggle more than once per ON or OFF period (no glitches).

Reset
REQ-024 reset low SHALL asynchronously force state IDLE, counters 0, drive_out 0, done 0, busy 0, cmd_ready 1.
REQ-025 Reset mid-train SHALL drop drive_out immediately with no done strobe; first command after release is accepted normally.

Configuration
REQ-026 Macro PULSE_ABORT_EN defined: abort port exists; abort high in ON -> drive_out low next cycle, enter OFF with full OFF_CYCLES, remaining count cleared, then normal done.
REQ-027 With PULSE_ABORT_EN: abort in OFF clears remaining count, current OFF completes; abort in IDLE or in the acceptance cycle SHALL be ignored.
REQ-028 Macro undefined: no abort port; behaviour per REQ-013..023 only.

Structure
REQ-029 Package pulse_train_pkg SHALL hold the state enum type and the default ON/OFF cycle constants.
REQ-030 One sub-module, pulse_timer (loadable down-counter with expire flag), SHALL implement ON/OFF timing.

Verification (ON_CYCLES=4, OFF_CYCLES=3)
REQ-031 cmd_count=2 accepted at cycle 0 -> drive_out high cycles 1-4 and 8-11, low 5-7 and 12-14, done at cycle 15 only.
REQ-032 cmd_count=0 at cycle 0 -> drive_out never high, done at cycle 1, cmd_ready high at cycle 1.
REQ-033 cmd_valid held high continuously, cmd_count=1 -> pulses every 8 cycles (4 high, 3 low, 1 idle), one done per pulse.
REQ-034 reset asserted at cycle 6 of a cmd_count=3 train -> drive_out 0 immediately, no done, cmd_ready 1; new cmd_count=1 after release runs normally.
REQ-035 PULSE_ABORT_EN, cmd_count=3, abort at cycle 2 -> drive_out low from cycle 3, low through cycle 5, done at cycle 6.
REQ-036 New cmd_valid with cmd_count=5 during busy -> ignored; original train count and done timing unchanged.
